systolic_skew_feeder_4: RTL and testbench

- Left-edge feeder for the 4x4 systolic array.
- Accepts one 4-lane row vector per cycle over a valid/ready handshake.
- Re-times the vector into the diagonal wavefront the array needs: lane i is delayed i cycles relative to lane 0.
- Drives array_en_left_i_0 / array_data_left_i_0 and signals when a burst has fully drained into the array.

---
 rtl/systolic_skew_feeder_4.sv | 136 +++++++++++++
 tb/tb_systolic_skew_feeder_4.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder_4.sv
// Left-edge feeder for a 4x4 systolic array. Accepts one 4-lane row vector per
// cycle and re-times it into a diagonal wavefront: lane i lags lane 0 by i cycles.
// A burst ends with a last-qualified vector; a 3-cycle drain then a done pulse follow.
module systolic_skew_feeder_4 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    skew_clk,
  input  logic                    skew_rst_n,
  input  logic                    skew_in_valid,
  output logic                    skew_in_ready,
  input  logic                    skew_in_last,
  input  logic [4*DATA_WIDTH-1:0] skew_in_data,
  output logic                    skew_out_en_0,
  output logic                    skew_out_en_1,
  output logic                    skew_out_en_2,
  output logic                    skew_out_en_3,
  output logic [DATA_WIDTH-1:0]   skew_out_data_0,
  output logic [DATA_WIDTH-1:0]   skew_out_data_1,
  output logic [DATA_WIDTH-1:0]   skew_out_data_2,
  output logic [DATA_WIDTH-1:0]   skew_out_data_3,
  output logic                    skew_done,
  output logic                    skew_busy,
  output logic [CNT_WIDTH-1:0]    skew_vec_cnt
);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             drain_q, drain_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   accept;
  logic [3:0]             lane_en;
  logic [DATA_WIDTH-1:0]  lane_data [4];

  assign accept = skew_in_valid & skew_in_ready;

  // State register.
  always_ff @(posedge skew_clk or negedge skew_rst_n) begin
    if (!skew_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = skew_in_last ? StDrain : StStream;
      end
      StStream: begin
        if (accept && skew_in_last) state_d = StDrain;
      end
      StDrain: begin
        if (drain_q == 2'd2) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from registered state; ready never looks at valid.
  always_comb begin
    skew_in_ready = (state_q == StIdle) || (state_q == StStream);
    skew_busy     = (state_q != StIdle);
    skew_done     = (state_q == StDone);
  end

  // Drain counter and saturating accepted-vector counter next state.
  always_comb begin
    drain_d = drain_q;
    cnt_d   = cnt_q;
    if (state_q == StDrain) drain_d = drain_q + 2'd1;
    if (accept && skew_in_last) drain_d = 2'd0;
    if (accept) begin
      if (state_q == StIdle) begin
        cnt_d = CNT_WIDTH'(1);
      end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Drain and vector counter registers.
  always_ff @(posedge skew_clk or negedge skew_rst_n) begin
    if (!skew_rst_n) begin
      drain_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  assign skew_vec_cnt = cnt_q;

  // Lane g is a chain of g+1 flops; non-accept cycles inject zero bubbles so
  // gaps stay aligned with the skew.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [g:0]            en_q;
    logic [DATA_WIDTH-1:0] data_q [g+1];

    // Shift the lane's delay chain.
    always_ff @(posedge skew_clk or negedge skew_rst_n) begin
      if (!skew_rst_n) begin
        en_q <= '0;
        for (int s = 0; s <= g; s++) data_q[s] <= '0;
      end else begin
        en_q[0]   <= accept;
        data_q[0] <= accept ? skew_in_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= g; s++) begin
          en_q[s]   <= en_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
    end

    assign lane_en[g]   = en_q[g];
    assign lane_data[g] = data_q[g];
  end

  assign skew_out_en_0   = lane_en[0];
  assign skew_out_en_1   = lane_en[1];
  assign skew_out_en_2   = lane_en[2];
  assign skew_out_en_3   = lane_en[3];
  assign skew_out_data_0 = lane_data[0];
  assign skew_out_data_1 = lane_data[1];
  assign skew_out_data_2 = lane_data[2];
  assign skew_out_data_3 = lane_data[3];

endmodule

// File: tb/tb_systolic_skew_feeder_4.sv
// Bench for systolic_skew_feeder_4: a cycle-history reference model predicts every
// lane from the vector accepted i+1 cycles earlier, and burst control from the
// cycle of the last accepted last-vector. A second instance uses a 2-bit counter.
module tb_systolic_skew_feeder_4;
  localparam int DW = 32;
  localparam int N  = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [4*DW-1:0] in_data = '0;

  logic          ready, done, busy, en0, en1, en2, en3;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [15:0]   cnt;
  logic          ready_b, done_b, busy_b, en0_b, en1_b, en2_b, en3_b;
  logic [DW-1:0] d0_b, d1_b, d2_b, d3_b;
  logic [1:0]    cnt_b;

  systolic_skew_feeder_4 #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .skew_clk(clk), .skew_rst_n(rst_n), .skew_in_valid(in_valid), .skew_in_ready(ready),
    .skew_in_last(in_last), .skew_in_data(in_data),
    .skew_out_en_0(en0), .skew_out_en_1(en1), .skew_out_en_2(en2), .skew_out_en_3(en3),
    .skew_out_data_0(d0), .skew_out_data_1(d1), .skew_out_data_2(d2), .skew_out_data_3(d3),
    .skew_done(done), .skew_busy(busy), .skew_vec_cnt(cnt)
  );

  systolic_skew_feeder_4 #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
    .skew_clk(clk), .skew_rst_n(rst_n), .skew_in_valid(in_valid), .skew_in_ready(ready_b),
    .skew_in_last(in_last), .skew_in_data(in_data),
    .skew_out_en_0(en0_b), .skew_out_en_1(en1_b), .skew_out_en_2(en2_b),
    .skew_out_en_3(en3_b), .skew_out_data_0(d0_b), .skew_out_data_1(d1_b),
    .skew_out_data_2(d2_b), .skew_out_data_3(d3_b),
    .skew_done(done_b), .skew_busy(busy_b), .skew_vec_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  wire [3:0]      obs_en    = {en3, en2, en1, en0};
  wire [4*DW-1:0] obs_data  = {d3, d2, d1, d0};
  wire [2:0]      obs_ctl   = {ready, done, busy};
  wire [3:0]      obs_en_b  = {en3_b, en2_b, en1_b, en0_b};
  wire [4*DW-1:0] obs_data_b = {d3_b, d2_b, d1_b, d0_b};
  wire [2:0]      obs_ctl_b = {ready_b, done_b, busy_b};

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int              cyc = 0;
  bit              h_en [N];
  logic [4*DW-1:0] h_data [N];
  int              last_k = -100;
  bit              in_burst = 0;
  int              m_cnt = 0;
  int              m_cnt2 = 0;

  logic [3:0]      exp_en;
  logic [4*DW-1:0] exp_data;
  logic [2:0]      exp_ctl;
  bit              exp_ready;

  function automatic logic [4*DW-1:0] mk(input int n);
    logic [4*DW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*DW +: DW] = DW'(16 * n + i);
    return v;
  endfunction

  // Drive inputs for the current cycle and form expectations at the negedge.
  task automatic drive(input bit v, input bit l, input logic [4*DW-1:0] d);
    in_valid = v;
    in_last  = l;
    in_data  = d;
    @(negedge clk);
    exp_ready = !((cyc > last_k) && (cyc <= last_k + 4));
    exp_ctl   = {exp_ready, (cyc == last_k + 4), (in_burst || !exp_ready)};
    for (int i = 0; i < 4; i++) begin
      int idx = cyc - 1 - i;
      exp_en[i]            = (idx >= 0) ? h_en[idx] : 1'b0;
      exp_data[i*DW +: DW] = ((idx >= 0) && h_en[idx]) ? h_data[idx][i*DW +: DW] : '0;
    end
  endtask

  // Record this cycle's handshake in the model and move past the next posedge.
  task automatic advance();
    bit acc;
    acc         = in_valid && exp_ready;
    h_en[cyc]   = acc;
    h_data[cyc] = in_data;
    if (acc) begin
      if (!in_burst) begin
        m_cnt  = 1;
        m_cnt2 = 1;
      end else begin
        m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
      end
      if (in_last) begin
        in_burst = 0;
        last_k   = cyc;
      end else begin
        in_burst = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 1'b0, '0);
      checks++;
      if (obs_en !== 4'b0 || obs_data !== '0) begin
        errors++; $display("FAIL reset_lanes got=%b/%h want=0", obs_en, obs_data);
      end
      checks++;
      if (obs_ctl !== 3'b100 || cnt !== 16'd0 || cnt_b !== 2'd0) begin
        errors++; $display("FAIL reset_ctl got=%b cnt=%0d/%0d want=100 cnt=0", obs_ctl, cnt, cnt_b);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 10; r++) begin
      drive(r < 4, r == 3, mk(r));
      checks++;
      if (obs_en !== exp_en || obs_data !== exp_data) begin
        errors++; $display("FAIL b2b_lanes r=%0d got=%b/%h want=%b/%h", r, obs_en, obs_data, exp_en, exp_data);
      end
      checks++;
      if (obs_ctl !== exp_ctl || cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL b2b_ctl r=%0d got=%b/%0d want=%b/%0d", r, obs_ctl, cnt, exp_ctl, m_cnt);
      end
      if (r >= 1 && r <= 4) begin
        checks++;
        if (!en0 || d0 !== DW'(16 * (r - 1))) begin
          errors++; $display("FAIL b2b_lane0 r=%0d got=%b/%0d want=1/%0d", r, en0, d0, 16 * (r - 1));
        end
      end
      if (r >= 4 && r <= 7) begin
        checks++;
        if (!en3 || d3 !== DW'(16 * (r - 4) + 3) || ready !== 1'b0) begin
          errors++; $display("FAIL b2b_lane3 r=%0d got=%b/%0d rdy=%b want=1/%0d rdy=0", r, en3, d3, ready, 16 * (r - 4) + 3);
        end
      end
      if (r == 7) begin
        checks++;
        if (done !== 1'b1 || cnt !== 16'd4) begin
          errors++; $display("FAIL b2b_done got=%b cnt=%0d want=1 cnt=4", done, cnt);
        end
      end
      if (r == 8) begin
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL b2b_ready got=%b done=%b want=1 done=0", ready, done);
        end
      end
      advance();
    end
  endtask

  // Generic model-checked scenario: vld/lst patterns with given data seed.
  task automatic run_pattern(input string name, input logic [15:0] vld, input logic [15:0] lst,
                             input int len, input bit rnd_data);
    for (int r = 0; r < len; r++) begin
      logic [4*DW-1:0] d;
      d = rnd_data ? {$urandom, $urandom, $urandom, $urandom} : mk(r + 7);
      drive(vld[r], lst[r], d);
      checks++;
      if (obs_en !== exp_en || obs_data !== exp_data) begin
        errors++; $display("FAIL %s_lanes r=%0d got=%b/%h want=%b/%h", name, r, obs_en, obs_data, exp_en, exp_data);
      end
      checks++;
      if (obs_ctl !== exp_ctl || cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL %s_ctl r=%0d got=%b/%0d want=%b/%0d", name, r, obs_ctl, cnt, exp_ctl, m_cnt);
      end
      checks++;
      if (obs_en_b !== exp_en || obs_data_b !== exp_data || obs_ctl_b !== exp_ctl || cnt_b !== 2'(m_cnt2)) begin
        errors++; $display("FAIL %s_sat r=%0d got=%b/%b/%0d want=%b/%b/%0d", name, r, obs_en_b, obs_ctl_b, cnt_b, exp_en, exp_ctl, m_cnt2);
      end
      advance();
    end
  endtask

  task automatic test_bubble();
    // Valid low on the second cycle of a 3-vector burst.
    run_pattern("bubble", 16'b0000_0000_0000_1101, 16'b0000_0000_0000_1000, 12, 1'b0);
  endtask

  task automatic test_single();
    for (int r = 0; r < 7; r++) begin
      drive(r == 0, r == 0, {32'd4, 32'd3, 32'd2, 32'd1});
      checks++;
      if (obs_en !== exp_en || obs_data !== exp_data || obs_ctl !== exp_ctl) begin
        errors++; $display("FAIL single r=%0d got=%b/%h/%b want=%b/%h/%b", r, obs_en, obs_data, obs_ctl, exp_en, exp_data, exp_ctl);
      end
      if (r >= 1 && r <= 4) begin
        checks++;
        if (obs_en !== (4'b1 << (r - 1)) || obs_data[(r-1)*DW +: DW] !== DW'(r) || cnt !== 16'd1) begin
          errors++; $display("FAIL single_lane r=%0d got=%b/%0d cnt=%0d want=%b/%0d cnt=1", r, obs_en, obs_data[(r-1)*DW +: DW], cnt, 4'b1 << (r - 1), r);
        end
      end
      if (r == 4) begin
        checks++;
        if (done !== 1'b1) begin
          errors++; $display("FAIL single_done got=%b want=1", done);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    // Two-vector burst, then valid held high with last through drain/done.
    run_pattern("stall", 16'b0000_0000_1111_1111, 16'b0000_0000_1111_1110, 14, 1'b0);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 12; r++) begin
      drive(r < 6, r == 5, mk(r + 3));
      if (r >= 1 && r <= 6) begin
        int want;
        want = (r < 3) ? r : 3;
        checks++;
        if (cnt_b !== 2'(want) || cnt !== 16'(r)) begin
          errors++; $display("FAIL sat_cnt r=%0d got=%0d/%0d want=%0d/%0d", r, cnt_b, cnt, want, r);
        end
      end
      checks++;
      if (obs_ctl_b !== exp_ctl || obs_en_b !== exp_en) begin
        errors++; $display("FAIL sat_ctl r=%0d got=%b/%b want=%b/%b", r, obs_ctl_b, obs_en_b, exp_ctl, exp_en);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 10; b++) begin
      logic [15:0] v, l;
      v = 16'($urandom);
      l = 16'($urandom) & 16'($urandom) & 16'($urandom);
      l[12] = 1'b1;
      v[12] = 1'b1;
      run_pattern("rand", v, l, 16, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, mk(r + 20));
      advance();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_en !== 4'b0 || obs_data !== '0 || obs_en_b !== 4'b0 || obs_data_b !== '0) begin
      errors++; $display("FAIL rstmid_lanes got=%b/%h want=0", obs_en, obs_data);
    end
    checks++;
    if (obs_ctl !== 3'b100 || cnt !== 16'd0 || cnt_b !== 2'd0) begin
      errors++; $display("FAIL rstmid_ctl got=%b cnt=%0d want=100 cnt=0", obs_ctl, cnt);
    end
    in_valid = 1'b0;
    for (int i = 0; i <= cyc + 4 && i < N; i++) h_en[i] = 1'b0;
    last_k   = -100;
    in_burst = 0;
    m_cnt    = 0;
    m_cnt2   = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    run_pattern("rstmid", 16'b0000_0000_0000_0000, 16'b0, 6, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      h_en[i]   = 1'b0;
      h_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_bubble();
    test_single();
    test_stall();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
